// File: rtl/axi_rx_command_router.sv
// Command packet router: decodes opcode/ID framed packets from the RX command FIFO and
// forwards matching ones downstream with tdest = table index; drops dup/unknown/runt packets.
module axi_rx_command_router #(
  parameter int                   DATA_WIDTH  = 32,
  parameter int                   NUM_CMD     = 5,
  parameter int                   DEST_WIDTH  = 4,
  parameter logic [NUM_CMD*32-1:0] CMD_TABLE  = {32'h57574441, 32'h52524646, 32'h52524343,
                                                 32'h57574646, 32'h57574343},
  parameter int                   MAX_PAYLOAD = 256,
  parameter bit                   DUP_FILTER  = 1'b1
) (
  input  logic                    axi_tclk,
  input  logic                    axi_treset,
  input  logic                    enable_rx_decode,
  input  logic [DATA_WIDTH-1:0]   cmd_axis_tdata,
  input  logic                    cmd_axis_tvalid,
  input  logic                    cmd_axis_tlast,
  output logic                    cmd_axis_tready,
  output logic [DATA_WIDTH-1:0]   tdata,
  output logic                    tvalid,
  output logic                    tlast,
  output logic [DATA_WIDTH/8-1:0] tkeep,
  output logic [DEST_WIDTH-1:0]   tdest,
  output logic [3:0]              tid,
  output logic [31:0]             tuser,
  input  logic                    tready,
  output logic [15:0]             pkt_count,
  output logic [15:0]             drop_count,
  output logic [15:0]             trunc_count,
  output logic [31:0]             last_cmd_id
);
  localparam int CW = $clog2(MAX_PAYLOAD + 1);

  typedef enum logic [2:0] {S_IDLE, S_OPCODE, S_ID, S_PAYLOAD, S_DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [31:0]             opcode_q, last_id_q;
  logic                    hit_q;
  logic [DEST_WIDTH-1:0]   idx_q;
  logic [CW-1:0]           beat_q, beat_d;
  logic [15:0]             pkt_q, drop_q, trunc_q;
  logic                    tvalid_q, tlast_q;
  logic [DATA_WIDTH-1:0]   tdata_q;
  logic [DEST_WIDTH-1:0]   tdest_q;
  logic [31:0]             tuser_q;

  logic                    acc, out_free, rdy, load, ld_last, latch_op, latch_id;
  logic                    pkt_inc, drop_inc, trunc_inc, m_hit;
  logic [DATA_WIDTH-1:0]   ld_data;
  logic [31:0]             ld_user;
  logic [DEST_WIDTH-1:0]   m_idx;

  assign acc      = cmd_axis_tvalid & rdy;
  assign out_free = !tvalid_q | tready;

  // Scan from the top so the lowest matching index wins.
  always_comb begin
    m_hit = 1'b0;
    m_idx = '0;
    for (int i = NUM_CMD - 1; i >= 0; i--) begin
      if (cmd_axis_tdata[31:0] == CMD_TABLE[32*i +: 32]) begin
        m_hit = 1'b1;
        m_idx = DEST_WIDTH'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rdy       = 1'b0;
    load      = 1'b0;
    ld_data   = cmd_axis_tdata;
    ld_last   = 1'b0;
    ld_user   = last_id_q;
    latch_op  = 1'b0;
    latch_id  = 1'b0;
    pkt_inc   = 1'b0;
    drop_inc  = 1'b0;
    trunc_inc = 1'b0;
    beat_d    = beat_q;
    case (state_q)
      S_IDLE: if (enable_rx_decode && !tvalid_q) state_d = S_OPCODE;
      S_OPCODE: begin
        rdy = 1'b1;
        if (acc) begin
          latch_op = 1'b1;
          if (cmd_axis_tlast) begin
            drop_inc = 1'b1;
            state_d  = S_IDLE;
          end else begin
            state_d  = S_ID;
          end
        end
      end
      S_ID: begin
        rdy = out_free;
        if (acc) begin
          if (!hit_q || (DUP_FILTER && cmd_axis_tdata[31:0] == last_id_q)) begin
            drop_inc = 1'b1;
            state_d  = cmd_axis_tlast ? S_IDLE : S_DRAIN;
          end else begin
            load     = 1'b1;
            ld_data  = DATA_WIDTH'(opcode_q);
            ld_last  = cmd_axis_tlast;
            ld_user  = cmd_axis_tdata[31:0];
            latch_id = 1'b1;
            pkt_inc  = 1'b1;
            beat_d   = '0;
            state_d  = cmd_axis_tlast ? S_IDLE : S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        rdy = out_free;
        if (acc) begin
          load   = 1'b1;
          beat_d = CW'(beat_q + 1'b1);
          if (cmd_axis_tlast) begin
            ld_last = 1'b1;
            state_d = S_IDLE;
          end else if (beat_q == CW'(MAX_PAYLOAD - 1)) begin
            ld_last   = 1'b1;
            trunc_inc = 1'b1;
            state_d   = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        rdy = 1'b1;
        if (acc && cmd_axis_tlast) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge axi_tclk) begin
    if (axi_treset) begin
      state_q   <= S_IDLE;
      opcode_q  <= '0;
      hit_q     <= 1'b0;
      idx_q     <= '0;
      last_id_q <= '0;
      beat_q    <= '0;
      pkt_q     <= '0;
      drop_q    <= '0;
      trunc_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tdata_q   <= '0;
      tdest_q   <= '0;
      tuser_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (latch_op) begin
        opcode_q <= cmd_axis_tdata[31:0];
        hit_q    <= m_hit;
        idx_q    <= m_idx;
      end
      if (latch_id) last_id_q <= cmd_axis_tdata[31:0];
      if (pkt_inc && pkt_q != 16'hFFFF)     pkt_q   <= pkt_q + 16'd1;
      if (drop_inc && drop_q != 16'hFFFF)   drop_q  <= drop_q + 16'd1;
      if (trunc_inc && trunc_q != 16'hFFFF) trunc_q <= trunc_q + 16'd1;
      // Single output register: only reloaded when empty or draining this cycle.
      if (load) begin
        tvalid_q <= 1'b1;
        tdata_q  <= ld_data;
        tlast_q  <= ld_last;
        tdest_q  <= idx_q;
        tuser_q  <= ld_user;
      end else if (tready) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign cmd_axis_tready = rdy;
  assign tvalid          = tvalid_q;
  assign tdata           = tdata_q;
  assign tlast           = tlast_q;
  assign tdest           = tdest_q;
  assign tuser           = tuser_q;
  assign tkeep           = '1;
  assign tid             = '0;
  assign pkt_count       = pkt_q;
  assign drop_count      = drop_q;
  assign trunc_count     = trunc_q;
  assign last_cmd_id     = last_id_q;
endmodule
